// File: rtl/anubis_dec_key_sched_if.sv
// Key streams between the Anubis key expansion unit, the decryption key
// scheduler and the decryption round datapath.
interface anubis_dec_key_sched_if #(
    parameter int IDX_W = 4
);
    // Both streams use valid/ready: a word moves on a clock edge where valid
    // and ready are both high; once valid rises, the word stays put until it moves.
    logic [127:0]     key_in;
    logic             key_in_valid;
    logic             key_in_ready;
    logic [127:0]     key_out;
    logic             key_out_valid;
    logic             key_out_ready;
    logic [IDX_W-1:0] key_out_idx;
    logic             key_out_last;
    logic             busy;

    modport slave (
        input  key_in, key_in_valid, key_out_ready,
        output key_in_ready, key_out, key_out_valid, key_out_idx, key_out_last, busy
    );

    modport master (
        output key_in, key_in_valid, key_out_ready,
        input  key_in_ready, key_out, key_out_valid, key_out_idx, key_out_last, busy
    );
endinterface

// File: rtl/anubis_dec_key_sched.sv
// Anubis-128 decryption key scheduler: stacks K^0..K^R, then streams K^R,
// theta(K^(R-1))..theta(K^1), K^0 with the round index attached.
module anubis_dec_key_sched #(
    parameter int ROUNDS = 12,
    parameter int IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    anubis_dec_key_sched_if.slave   bus
);
    typedef enum logic {
        ST_LOAD,
        ST_EMIT
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS);
    localparam logic [IDX_W-1:0] PEN_IDX  = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    endfunction

    // Multiply by h[sel], h = {01,02,04,06}
    function automatic logic [7:0] mul_h(input logic [7:0] x, input logic [1:0] sel);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] r;
        x2 = xtime(x);
        x4 = xtime(x2);
        case (sel)
            2'd0:    r = x;
            2'd1:    r = x2;
            2'd2:    r = x4;
            default: r = x4 ^ x2;
        endcase
        return r;
    endfunction

    function automatic logic [127:0] theta(input logic [127:0] a);
        logic [127:0] b;
        logic [7:0]   acc;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ mul_h(a[127-8*(4*i+k) -: 8], 2'(j ^ k));
                end
                b[127-8*(4*i+j) -: 8] = acc;
            end
        end
        return b;
    endfunction

    state_e           state_q;
    logic [IDX_W-1:0] cnt_q;
    logic             in_ready_q;
    logic [127:0]     key_out_q;
    logic             key_out_valid_q;
    logic [IDX_W-1:0] key_out_idx_q;
    logic             key_out_last_q;
    logic             busy_q;

    logic [127:0]     mem_q [ROUNDS];

    logic             in_fire;
    logic             out_fire;
    logic             mem_we;
    logic [IDX_W-1:0] rd_addr;
    logic [127:0]     rd_key;
    logic [IDX_W-1:0] idx_inc;
    logic [127:0]     next_key_d;

    // in_ready_q is only high in LOAD and key_out_valid_q only in EMIT,
    // so the two transfers are mutually exclusive.
    assign in_fire  = bus.key_in_valid & in_ready_q;
    assign out_fire = key_out_valid_q & bus.key_out_ready;
    assign mem_we   = in_fire && (cnt_q != LAST_IDX);

    // LIFO read: key for round idx+1 lives at mem[ROUNDS-1-idx].
    assign rd_addr    = PEN_IDX - key_out_idx_q;
    assign rd_key     = mem_q[rd_addr];
    assign idx_inc    = key_out_idx_q + ONE;
    assign next_key_d = (idx_inc == LAST_IDX) ? rd_key : theta(rd_key);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[cnt_q] <= bus.key_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_LOAD;
            cnt_q           <= '0;
            in_ready_q      <= 1'b1;
            key_out_q       <= '0;
            key_out_valid_q <= 1'b0;
            key_out_idx_q   <= '0;
            key_out_last_q  <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_fire) begin
                        if (cnt_q == LAST_IDX) begin
                            // K^R bypasses the LIFO and becomes K'^0 directly.
                            key_out_q       <= bus.key_in;
                            key_out_idx_q   <= '0;
                            key_out_valid_q <= 1'b1;
                            key_out_last_q  <= (LAST_IDX == '0);
                            in_ready_q      <= 1'b0;
                            busy_q          <= 1'b1;
                            state_q         <= ST_EMIT;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_fire) begin
                        if (key_out_idx_q == LAST_IDX) begin
                            key_out_valid_q <= 1'b0;
                            key_out_last_q  <= 1'b0;
                            cnt_q           <= '0;
                            in_ready_q      <= 1'b1;
                            busy_q          <= 1'b0;
                            state_q         <= ST_LOAD;
                        end else begin
                            key_out_q      <= next_key_d;
                            key_out_idx_q  <= idx_inc;
                            key_out_last_q <= (idx_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.key_in_ready  = in_ready_q;
    assign bus.key_out       = key_out_q;
    assign bus.key_out_valid = key_out_valid_q;
    assign bus.key_out_idx   = key_out_idx_q;
    assign bus.key_out_last  = key_out_last_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_anubis_dec_key_sched.sv
// Directed bench for anubis_dec_key_sched: ordering, theta values,
// backpressure, ignore-while-busy, reset mid-emit and involution.
module tb_anubis_dec_key_sched;
    localparam int ROUNDS = 12;

    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;

    logic [127:0] kin [13];

    anubis_dec_key_sched_if #(.IDX_W(4)) bus ();

    anubis_dec_key_sched #(.ROUNDS(ROUNDS), .IDX_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference GF(2^8) multiply, shift-and-add with polynomial 0x11D.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1d) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] theta_model(input logic [127:0] a);
        logic [7:0]   h [4];
        logic [127:0] b;
        logic [7:0]   acc;
        h[0] = 8'h01; h[1] = 8'h02; h[2] = 8'h04; h[3] = 8'h06;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gf_mul(a[127-8*(4*i+k) -: 8], h[k ^ j]);
                end
                b[127-8*(4*i+j) -: 8] = acc;
            end
        end
        return b;
    endfunction

    task automatic send_key(input logic [127:0] k);
        int tries;
        tries = 0;
        bus.key_in       = k;
        bus.key_in_valid = 1'b1;
        while (!bus.key_in_ready && tries < 50) begin
            step();
            tries++;
        end
        if (!bus.key_in_ready) begin
            chk("send_timeout", 128'(0), 128'(1));
        end else begin
            step();
        end
        bus.key_in_valid = 1'b0;
    endtask

    task automatic load_all(input bit gaps);
        for (int r = 0; r <= ROUNDS; r++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.key_in       = {4{$urandom()}};
                    bus.key_in_valid = 1'b0;
                    step();
                end
            end
            send_key(kin[r]);
        end
    endtask

    task automatic recv(input int r, input logic [127:0] exp_key);
        int tries;
        tries = 0;
        bus.key_out_ready = 1'b1;
        while (!bus.key_out_valid && tries < 20) begin
            step();
            tries++;
        end
        if (!bus.key_out_valid) begin
            chk($sformatf("recv_timeout_r%0d", r), 128'(0), 128'(1));
        end else begin
            chk($sformatf("idx_r%0d", r), 128'(bus.key_out_idx), 128'(r));
            chk($sformatf("last_r%0d", r), 128'(bus.key_out_last), 128'(r == ROUNDS));
            chk($sformatf("key_r%0d", r), bus.key_out, exp_key);
            step();
        end
    endtask

    initial begin
        logic [127:0] x_key;
        logic [127:0] exp_key;
        logic [127:0] hold_key;

        tests_run         = 0;
        tests_failed      = 0;
        rst_n             = 1'b0;
        bus.key_in        = '0;
        bus.key_in_valid  = 1'b0;
        bus.key_out_ready = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_in_ready", 128'(bus.key_in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.key_out_valid), 128'(0));
        chk("rst_key_out", bus.key_out, 128'(0));
        chk("rst_idx", 128'(bus.key_out_idx), 128'(0));
        chk("rst_last", 128'(bus.key_out_last), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        rst_n = 1'b1;

        // key_out_ready with nothing valid does nothing
        bus.key_out_ready = 1'b1;
        step();
        step();
        chk("idle_out_valid", 128'(bus.key_out_valid), 128'(0));
        chk("idle_in_ready", 128'(bus.key_in_ready), 128'(1));
        bus.key_out_ready = 1'b0;

        // Ordering with endpoint passthrough, random input gaps
        for (int r = 0; r <= ROUNDS; r++) kin[r] = {16{8'(r)}};
        load_all(1'b1);
        chk("k0_valid_next_cycle", 128'(bus.key_out_valid), 128'(1));
        chk("k0_passthrough", bus.key_out, {16{8'h0c}});
        chk("k0_idx", 128'(bus.key_out_idx), 128'(0));
        chk("emit_busy", 128'(bus.busy), 128'(1));
        chk("emit_in_ready", 128'(bus.key_in_ready), 128'(0));

        // Backpressure for 7 cycles, with a garbage key offered meanwhile
        hold_key         = bus.key_out;
        bus.key_in       = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        bus.key_in_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step();
            chk($sformatf("bp_valid_c%0d", c), 128'(bus.key_out_valid), 128'(1));
            chk($sformatf("bp_key_c%0d", c), bus.key_out, hold_key);
            chk($sformatf("bp_idx_c%0d", c), 128'(bus.key_out_idx), 128'(0));
        end

        // Ready held high: one key per cycle, no waiting allowed
        bus.key_out_ready = 1'b1;
        for (int r = 0; r <= ROUNDS; r++) begin
            if (r == ROUNDS) bus.key_in_valid = 1'b0;
            chk($sformatf("seq_valid_r%0d", r), 128'(bus.key_out_valid), 128'(1));
            chk($sformatf("seq_idx_r%0d", r), 128'(bus.key_out_idx), 128'(r));
            chk($sformatf("seq_last_r%0d", r), 128'(bus.key_out_last), 128'(r == ROUNDS));
            chk($sformatf("seq_key_r%0d", r), bus.key_out, {16{8'(ROUNDS - r)}});
            step();
        end
        bus.key_out_ready = 1'b0;
        chk("done_out_valid", 128'(bus.key_out_valid), 128'(0));
        chk("done_in_ready", 128'(bus.key_in_ready), 128'(1));
        chk("done_busy", 128'(bus.busy), 128'(0));

        // theta values on single-byte and uniform keys
        for (int r = 0; r <= ROUNDS; r++) kin[r] = '0;
        kin[0]  = 128'h0123456789abcdeffedcba9876543210;
        kin[1]  = 128'h00000000000000000000000000000001;
        kin[6]  = {16{8'h01}};
        kin[11] = 128'h01000000000000000000000000000000;
        kin[12] = 128'hcafef00d112233445566778899aabbcc;
        load_all(1'b0);
        for (int r = 0; r <= ROUNDS; r++) begin
            case (r)
                0:       exp_key = 128'hcafef00d112233445566778899aabbcc;
                1:       exp_key = 128'h01020406000000000000000000000000;
                6:       exp_key = {16{8'h01}};
                11:      exp_key = 128'h00000000000000000000000006040201;
                12:      exp_key = 128'h0123456789abcdeffedcba9876543210;
                default: exp_key = '0;
            endcase
            recv(r, exp_key);
        end
        bus.key_out_ready = 1'b0;

        // Reset mid-emit, then reload with the involution vector
        x_key = 128'hdb1353450102030405060708090a0b0c;
        for (int r = 0; r <= ROUNDS; r++) kin[r] = '0;
        kin[0]  = 128'h00112233445566778899aabbccddeeff;
        kin[5]  = theta_model(x_key);
        kin[12] = {16{8'ha5}};
        load_all(1'b0);
        for (int r = 0; r < 5; r++) begin
            recv(r, (r == 0) ? {16{8'ha5}} : 128'(0));
        end
        bus.key_out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_out_valid", 128'(bus.key_out_valid), 128'(0));
        chk("midrst_in_ready", 128'(bus.key_in_ready), 128'(1));
        chk("midrst_busy", 128'(bus.busy), 128'(0));
        chk("midrst_idx", 128'(bus.key_out_idx), 128'(0));
        chk("midrst_key", bus.key_out, 128'(0));

        load_all(1'b1);
        for (int r = 0; r <= ROUNDS; r++) begin
            case (r)
                0:       exp_key = {16{8'ha5}};
                7:       exp_key = 128'hdb1353450102030405060708090a0b0c;
                12:      exp_key = 128'h00112233445566778899aabbccddeeff;
                default: exp_key = '0;
            endcase
            recv(r, exp_key);
        end
        bus.key_out_ready = 1'b0;
        step();
        chk("end_out_valid", 128'(bus.key_out_valid), 128'(0));
        chk("end_in_ready", 128'(bus.key_in_ready), 128'(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
